// File: rtl/vec_serializer_if.sv
// Vector-in / element-out handshake bundle for vec_serializer.
// The master side presents vectors and consumes elements; the slave side is the serializer.
interface vec_serializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned IDXW = $clog2(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec [DEPTH];
  logic [IDXW:0]    in_len;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             done;

  modport master (
    output in_valid, in_vec, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, done
  );

  modport slave (
    input  in_valid, in_vec, in_len, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, done
  );
endinterface

// File: rtl/vec_serializer.sv
// Parallel-load vector serializer: captures one DEPTH-element vector and streams its
// first in_len elements out in index order, with zero-bubble reload and a done pulse.
module vec_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  vec_serializer_if.slave   bus
);
  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned LENW = IDXW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] vbuf [DEPTH];
  logic [IDXW-1:0]  idx, idx_n;
  logic [LENW-1:0]  len_q, len_n, len_clamp;
  logic             done_q, done_n;
  logic             last, ready_c, load, out_hs;

  assign len_clamp = (bus.in_len > LENW'(DEPTH)) ? LENW'(DEPTH) : bus.in_len;
  assign last      = (state == SEND) && (LENW'(idx) == (len_q - LENW'(1)));

  // Ready also in the cycle the final element leaves, so the next vector loads without a gap
  assign ready_c = ((state == IDLE) || ((state == SEND) && last && bus.out_ready)) && !flush;
  assign load    = bus.in_valid && ready_c;
  assign out_hs  = (state == SEND) && bus.out_ready;

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = vbuf[idx];
  assign bus.out_idx   = idx;
  assign bus.out_last  = last;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      len_q  <= len_n;
      done_q <= done_n;
    end
  end

  // Element buffer is written only on the load handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) vbuf[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < int'(DEPTH); i++) vbuf[i] <= bus.in_vec[i];
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len_q;
    done_n  = 1'b0;
    if (flush) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      if (out_hs) begin
        if (last) begin
          state_n = IDLE;
          idx_n   = '0;
          done_n  = 1'b1;
        end else begin
          idx_n = idx + IDXW'(1);
        end
      end
      // A same-cycle load overrides the return to IDLE
      if (load) begin
        len_n = len_clamp;
        idx_n = '0;
        if (len_clamp == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = SEND;
        end
      end
    end
  end
endmodule

// File: doc/vec_serializer.md
Name: vec_serializer

Overview:
- Accepts one DEPTH-element vector in parallel through a valid/ready handshake.
- Streams the vector's first in_len elements out, one per handshake, in index order.
- Sits between the vector register file / vector pipeline registers and scalar consumers such as the memory store port and the scalar writeback path.
- Supports back-to-back vectors with no bubble, synchronous flush, and a done pulse per vector.

Parameters:
- WIDTH, 8, bit width of one element.
- DEPTH, 4, number of elements per vector; must be >= 2.
- IDXW, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous abort of the current vector.
- in_valid  input  1  in_vec/in_len valid.
- in_ready  output  1  serializer can accept a vector this cycle.
- in_vec  input  WIDTH x [0:DEPTH-1]  unpacked array of vector elements.
- in_len  input  IDXW+1  number of elements to emit, 0..DEPTH; values above DEPTH clamp to DEPTH.
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  consumer accepts the element.
- out_data  output  WIDTH  current element.
- out_idx  output  IDXW  index of current element.
- out_last  output  1  current element is the final one of the vector.
- done  output  1  one-cycle pulse after the final element handshakes, or after a zero-length vector is accepted.

Behaviour:
- Reset, asynchronous:
  - state=IDLE; element buffer all 0; idx=0; len_q=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, done=0.
  - in_ready=1 once reset deasserts.
- Registered state: IDLE, SEND. Element buffer is DEPTH x WIDTH flops, idx counter, len_q.
- Load handshake is in_valid && in_ready:
  - Capture in_vec into the buffer and len_q = min(in_len, DEPTH); set idx=0.
  - If the clamped length is 0: stay or return to IDLE; done=1 next cycle; no output element.
  - Otherwise, next state is SEND.
- in_ready is combinational: (state==IDLE || (state==SEND && out_last && out_ready)) && !flush.
  - A new vector can load in the same cycle the previous last element handshakes, so there is no bubble.
- SEND outputs:
  - out_valid=1, out_data=buffer[idx], out_idx=idx, out_last=(idx==len_q-1).
  - These are driven from registers only; no combinational path from in_* to out_*.
- Handshake out_valid && out_ready:
  - If not out_last: idx increments.
  - If out_last: done=1 next cycle, and state goes to IDLE, unless a load occurs in the same cycle. On a same-cycle load, the new vector is captured and the state stays SEND (or goes IDLE if its length is 0).
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last are held stable. out_valid never drops without a handshake, except on flush or reset.
- Latency:
  - First element: out_valid rises one cycle after the load handshake.
  - Steady state: one element per cycle with out_ready held high.
  - A vector of length L occupies exactly L SEND cycles.
- done:
  - Registered, high exactly one cycle per completed vector.
  - Back-to-back completions give consecutive done pulses.
- flush:
  - Priority over everything except reset.
  - On the next edge: state=IDLE, idx=0, out_valid=0, done=0.
  - No done pulse for the aborted vector.
  - in_ready=0 during the flush cycle, so no load occurs.
  - Buffer contents are don't-care after flush.
- in_vec changes while in SEND have no effect; the buffer is written only on the load handshake.
- Reset mid-SEND: outputs go to reset values immediately (asynchronous); no done pulse.

Test Plan:
1. Basic: WIDTH=8, DEPTH=4; load {0x11,0x22,0x33,0x44}, in_len=4, out_ready=1.
   - Required: out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after load.
   - out_idx 0..3; out_last only with 0x44; done high the cycle after 0x44; in_ready high during the 0x44 cycle.
2. Backpressure: same vector, in_len=3, out_ready toggling 1,0,0,1,1.
   - Required: 0x22 held stable across the stall cycles.
   - Exactly 3 handshakes (0x11,0x22,0x33); out_last with 0x33; single done pulse; 0x44 never emitted.
3. Back-to-back: second vector {0xA0,0xA1,0xA2,0xA3}, len 2, presented with in_valid held.
   - Required: load accepted in the cycle 0x44 handshakes.
   - Next cycle out_data=0xA0 with no idle gap, then 0xA1 with out_last.
   - done pulses on two consecutive vector completions.
4. Length edge cases:
   - in_len=0 -> no out_valid; done=1 next cycle; in_ready stays 1.
   - in_len=7 -> clamped, exactly 4 elements emitted.
5. Flush: assert flush while out_idx=1 of a len-4 vector.
   - Required: out_valid=0 the next cycle and no done pulse.
   - in_ready=0 during the flush cycle, 1 the following cycle.
   - A fresh load then emits from index 0.
6. Async reset mid-SEND (idx=2): assert reset between clock edges.
   - Required: out_valid, out_data, out_idx and done drop to 0 immediately.
   - in_ready=1 after release; next load behaves as in scenario 1.
